// File: rtl/nanosoc_exp_pkg.sv
// nanosoc_exp_pkg
// Shared definitions for the nanosoc expansion-region interconnect:
// AHB-Lite HTRANS/HRESP encodings, the default (error) target state
// encoding and the decode-error counter width.
package nanosoc_exp_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam int ERR_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ERR1 = 2'b01,
      ST_ERR2 = 2'b10
   } err_state_e;

endpackage

// File: rtl/nanosoc_exp_err_target.sv
// nanosoc_exp_err_target
// Internal default target: answers accepted NONSEQ/SEQ accesses to unmapped
// addresses with the two-cycle AHB ERROR response and counts them.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   accept     qualifying default access accepted this cycle (HREADY=1, NONSEQ/SEQ)
//   force_err  start an ERROR response without counting (hung-target timeout)
//   ready      HREADYOUT contribution while the default target owns the data phase
//   resp       HRESP contribution while the default target owns the data phase
//   err_count  saturating count of decode errors
module nanosoc_exp_err_target
   import nanosoc_exp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 accept,
   input  logic                 force_err,
   output logic                 ready,
   output logic                 resp,
   output logic [ERR_CNT_W-1:0] err_count
);

   err_state_e           state_q, state_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
   logic                 count_en;

   always_comb begin
      state_d  = state_q;
      count_en = 1'b0;
      if (force_err) begin
         // Timeout-forced errors are not decode errors, so they are not counted.
         state_d = ST_ERR1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_d  = ST_ERR1;
                  count_en = 1'b1;
               end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: begin
               if (accept) begin
                  state_d  = ST_ERR1;
                  count_en = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      cnt_d = cnt_q;
      if (count_en && (cnt_q != {ERR_CNT_W{1'b1}})) begin
         cnt_d = cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready     = (state_q != ST_ERR1);
   assign resp      = (state_q == ST_IDLE) ? HRESP_OKAY : HRESP_ERROR;
   assign err_count = cnt_q;

endmodule

// File: rtl/nanosoc_exp_interconnect.sv
// nanosoc_exp_interconnect
// AHB-Lite target-side fabric for the nanosoc expansion region. Splits the
// region into NUM_TARGETS contiguous windows of 2^TGT_AWIDTH bytes starting at
// page BASE_PAGE; everything else goes to an internal error target. The
// data-phase owner is registered in dsel and its response is muxed back.
// Ports:
//   HCLK, HRESETn                 clock, synchronous active-low reset
//   HSELS/HADDRS/HTRANSS/HWRITES  initiator address phase
//   HREADYS                       bus HREADY in
//   HREADYOUTS/HRESPS/HRDATAS     response to the initiator
//   HSELM                         per-target select (one-hot or zero)
//   HREADYOUTM/HRESPM/HRDATAM     per-target responses, target i at [32i+31:32i]
//   err_count                     saturating decode-error count
//   tgt_fault                     sticky per-target timeout flags
// Optional feature: define NANOSOC_EXP_TIMEOUT_EN to turn targets that stall
// for TIMEOUT_CYCLES wait states into bus errors and decode them as unmapped.
module nanosoc_exp_interconnect
   import nanosoc_exp_pkg::*;
#(
   parameter int ADDRWIDTH      = 29,
   parameter int TGT_AWIDTH     = 12,
   parameter int NUM_TARGETS    = 2,
   parameter int BASE_PAGE      = 'h00010,
   parameter int TIMEOUT_CYCLES = 256
)(
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      HSELS,
   input  logic [ADDRWIDTH-1:0]      HADDRS,
   input  logic [1:0]                HTRANSS,
   input  logic                      HWRITES,
   input  logic                      HREADYS,
   output logic                      HREADYOUTS,
   output logic                      HRESPS,
   output logic [31:0]               HRDATAS,
   output logic [NUM_TARGETS-1:0]    HSELM,
   input  logic [NUM_TARGETS-1:0]    HREADYOUTM,
   input  logic [NUM_TARGETS-1:0]    HRESPM,
   input  logic [32*NUM_TARGETS-1:0] HRDATAM,
   output logic [ERR_CNT_W-1:0]      err_count,
   output logic [NUM_TARGETS-1:0]    tgt_fault
);

   localparam int                PAGE_W      = ADDRWIDTH - TGT_AWIDTH;
   localparam logic [PAGE_W-1:0] BASE_PAGE_L = PAGE_W'(BASE_PAGE);

   logic [PAGE_W-1:0]      idx;
   logic [NUM_TARGETS-1:0] hit;
   logic [NUM_TARGETS-1:0] fault;
   logic                   default_hit;
   logic                   def_accept;
   logic                   force_err;
   logic                   def_ready;
   logic                   def_resp;
   // Bit NUM_TARGETS is the default target; all-zero means no data phase.
   logic [NUM_TARGETS:0]   dsel_q, dsel_d;

   // Addresses below BASE_PAGE wrap to a large idx and fall through to default.
   assign idx = HADDRS[ADDRWIDTH-1:TGT_AWIDTH] - BASE_PAGE_L;

   generate
      for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_decode
         assign hit[gi] = HSELS && (idx == PAGE_W'(gi)) && !fault[gi];
      end
   endgenerate

   assign HSELM       = hit;
   assign default_hit = HSELS && !(|hit);
   assign def_accept  = HREADYS && default_hit &&
                        ((HTRANSS == HTRANS_NONSEQ) || (HTRANSS == HTRANS_SEQ));

   // A timeout hands the stalled data phase to the default target even though
   // HREADYS is low, so it takes priority over the normal load.
   always_comb begin
      dsel_d = dsel_q;
      if (force_err) begin
         dsel_d = {1'b1, {NUM_TARGETS{1'b0}}};
      end else if (HREADYS) begin
         dsel_d = {default_hit, hit};
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         dsel_q <= '0;
      end else begin
         dsel_q <= dsel_d;
      end
   end

   always_comb begin
      HREADYOUTS = 1'b1;
      HRESPS     = HRESP_OKAY;
      HRDATAS    = '0;
      if (dsel_q[NUM_TARGETS]) begin
         HREADYOUTS = def_ready;
         HRESPS     = def_resp;
      end else begin
         for (int i = 0; i < NUM_TARGETS; i++) begin
            if (dsel_q[i]) begin
               HREADYOUTS = HREADYOUTM[i];
               HRESPS     = HRESPM[i];
               HRDATAS    = HRDATAM[32*i +: 32];
            end
         end
      end
   end

   nanosoc_exp_err_target u_err_target (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .accept    (def_accept),
      .force_err (force_err),
      .ready     (def_ready),
      .resp      (def_resp),
      .err_count (err_count)
   );

`ifdef NANOSOC_EXP_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [NUM_TARGETS-1:0] fault_q, fault_d;
   logic [NUM_TARGETS-1:0] timeout;
   logic                   dsel_change;

   assign dsel_change = (dsel_d != dsel_q);

   generate
      for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_timeout
         logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

         // Fires during the TIMEOUT_CYCLES-th consecutive wait state.
         assign timeout[gi] = dsel_q[gi] && !HREADYOUTM[gi] &&
                              (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

         always_comb begin
            wait_cnt_d = '0;
            if (dsel_q[gi] && !HREADYOUTM[gi] && !dsel_change) begin
               wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
         end

         always_ff @(posedge HCLK) begin
            if (!HRESETn) begin
               wait_cnt_q <= '0;
            end else begin
               wait_cnt_q <= wait_cnt_d;
            end
         end
      end
   endgenerate

   assign fault_d = fault_q | timeout;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         fault_q <= '0;
      end else begin
         fault_q <= fault_d;
      end
   end

   assign fault     = fault_q;
   assign force_err = |timeout;
   assign tgt_fault = fault_q;
`else
   logic unused_timeout;

   assign fault          = '0;
   assign force_err      = 1'b0;
   assign tgt_fault      = '0;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // Write direction and in-window offset are the targets' business.
   logic unused_addr;
   assign unused_addr = ^{HWRITES, HADDRS[TGT_AWIDTH-1:0]};

endmodule

// File: tb/tb_nanosoc_exp_interconnect.sv
// tb_nanosoc_exp_interconnect
// Directed bench for nanosoc_exp_interconnect (2 targets, 29-bit region).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// HREADYS follows HREADYOUTS unless the override is enabled.
// Timeout tests run only when NANOSOC_EXP_TIMEOUT_EN is defined.
module tb_nanosoc_exp_interconnect;
   import nanosoc_exp_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSELS;
   logic [28:0] HADDRS;
   logic [1:0]  HTRANSS;
   logic        HWRITES;
   logic        hreadys;
   logic        HREADYOUTS;
   logic        HRESPS;
   logic [31:0] HRDATAS;
   logic [1:0]  HSELM;
   logic [1:0]  HREADYOUTM;
   logic [1:0]  HRESPM;
   logic [63:0] HRDATAM;
   logic [7:0]  err_count;
   logic [1:0]  tgt_fault;

   logic rdy_ovr_en;
   logic rdy_ovr;

   int n_checks = 0;
   int n_pass   = 0;

   assign hreadys = rdy_ovr_en ? rdy_ovr : HREADYOUTS;

   always #5 HCLK = ~HCLK;

   nanosoc_exp_interconnect #(
      .ADDRWIDTH      (29),
      .TGT_AWIDTH     (12),
      .NUM_TARGETS    (2),
      .BASE_PAGE      ('h00010),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .HSELS      (HSELS),
      .HADDRS     (HADDRS),
      .HTRANSS    (HTRANSS),
      .HWRITES    (HWRITES),
      .HREADYS    (hreadys),
      .HREADYOUTS (HREADYOUTS),
      .HRESPS     (HRESPS),
      .HRDATAS    (HRDATAS),
      .HSELM      (HSELM),
      .HREADYOUTM (HREADYOUTM),
      .HRESPM     (HRESPM),
      .HRDATAM    (HRDATAM),
      .err_count  (err_count),
      .tgt_fault  (tgt_fault)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
         $display("check %-22s act=0x%08h exp=0x%08h ok", tag, act, exp);
      end else begin
         $display("FAIL %-22s act=0x%08h exp=0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive_addr(input logic sel, input logic [28:0] a, input logic [1:0] t,
                             input logic w);
      HSELS   = sel;
      HADDRS  = a;
      HTRANSS = t;
      HWRITES = w;
   endtask

   task automatic drive_idle();
      drive_addr(1'b0, 29'h0, HTRANS_IDLE, 1'b0);
   endtask

   // Checks the initiator response in the current cycle.
   task automatic check_rsp(input string tag, input logic rdy, input logic rsp);
      #1;
      check_eq({tag, "_rdy"}, {31'd0, HREADYOUTS}, {31'd0, rdy});
      check_eq({tag, "_resp"}, {31'd0, HRESPS}, {31'd0, rsp});
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "bench timed out");
   end

   initial begin
      rdy_ovr_en = 1'b0;
      rdy_ovr    = 1'b1;
      HREADYOUTM = 2'b11;
      HRESPM     = 2'b00;
      HRDATAM    = '0;
      HRESETn    = 1'b0;
      // Decode is live during reset.
      drive_addr(1'b1, 29'h0001_1004, HTRANS_NONSEQ, 1'b0);
      step();
      step();
      #1;
      check_eq("rst_hselm", {30'd0, HSELM}, 32'h2);
      check_eq("rst_rdata", HRDATAS, 32'h0);
      check_eq("rst_errcnt", {24'd0, err_count}, 32'd0);
      check_eq("rst_fault", {30'd0, tgt_fault}, 32'd0);
      check_rsp("rst", 1'b1, 1'b0);
      drive_idle();
      HRESETn = 1'b1;
      step();

      // ---- read target 1 with two wait states ----
      drive_addr(1'b1, 29'h0001_1004, HTRANS_NONSEQ, 1'b0);
      #1;
      check_eq("t1_hselm", {30'd0, HSELM}, 32'h2);
      step();
      drive_idle();
      HREADYOUTM = 2'b01;
      HRESPM     = 2'b01;               // target 0 decoy error
      HRDATAM    = {32'hCAFE_0001, 32'hDEAD_0000};
      check_rsp("t1_wait1", 1'b0, 1'b0);
      step();
      check_rsp("t1_wait2", 1'b0, 1'b0);
      step();
      HREADYOUTM = 2'b11;
      check_rsp("t1_done", 1'b1, 1'b0);
      check_eq("t1_rdata", HRDATAS, 32'hCAFE_0001);
      step();
      HRESPM = 2'b00;
      #1;
      check_eq("desel_rdata", HRDATAS, 32'h0);
      check_rsp("desel", 1'b1, 1'b0);

      // ---- unmapped NONSEQ write ----
      drive_addr(1'b1, 29'h0002_0000, HTRANS_NONSEQ, 1'b1);
      #1;
      check_eq("unm_hselm", {30'd0, HSELM}, 32'h0);
      step();
      drive_idle();
      check_rsp("unm_err1", 1'b0, 1'b1);
      check_eq("unm_cnt1", {24'd0, err_count}, 32'd1);
      step();
      check_rsp("unm_err2", 1'b1, 1'b1);
      step();
      check_rsp("unm_after", 1'b1, 1'b0);

      // ---- IDLE transfer to unmapped: zero-wait OKAY ----
      drive_addr(1'b1, 29'h0002_0000, HTRANS_IDLE, 1'b0);
      step();
      drive_idle();
      check_rsp("idle_unm", 1'b1, 1'b0);
      check_eq("idle_cnt", {24'd0, err_count}, 32'd1);
      step();

      // ---- below BASE_PAGE ----
      drive_addr(1'b1, 29'h0000_F000, HTRANS_NONSEQ, 1'b0);
      step();
      drive_idle();
      check_rsp("below_err1", 1'b0, 1'b1);
      check_eq("below_cnt", {24'd0, err_count}, 32'd2);
      step();
      check_rsp("below_err2", 1'b1, 1'b1);
      step();

      // ---- target 0 read then idx==NUM_TARGETS back-to-back ----
      drive_addr(1'b1, 29'h0001_0000, HTRANS_NONSEQ, 1'b0);
      #1;
      check_eq("b2b_hselm0", {30'd0, HSELM}, 32'h1);
      step();
      HRDATAM = {32'h5555_5555, 32'h1234_ABCD};
      drive_addr(1'b1, 29'h0001_2000, HTRANS_NONSEQ, 1'b0);
      #1;
      check_eq("b2b_hselm_edge", {30'd0, HSELM}, 32'h0);
      check_eq("b2b_rdata", HRDATAS, 32'h1234_ABCD);
      check_rsp("b2b_t0", 1'b1, 1'b0);
      step();
      drive_idle();
      check_rsp("b2b_err1", 1'b0, 1'b1);
      check_eq("b2b_err_rdata", HRDATAS, 32'h0);
      check_eq("b2b_cnt", {24'd0, err_count}, 32'd3);
      step();
      check_rsp("b2b_err2", 1'b1, 1'b1);
      step();

      // ---- HREADYS low during address phase to target 1 ----
      rdy_ovr_en = 1'b1;
      rdy_ovr    = 1'b0;
      drive_addr(1'b1, 29'h0001_1000, HTRANS_NONSEQ, 1'b0);
      #1;
      check_eq("hrdy_hselm", {30'd0, HSELM}, 32'h2);
      step();
      HREADYOUTM = 2'b01;
      HRDATAM    = {32'hBEEF_0002, 32'h0};
      check_rsp("hrdy_hold", 1'b1, 1'b0);
      rdy_ovr = 1'b1;
      step();
      rdy_ovr_en = 1'b0;
      drive_idle();
      check_rsp("hrdy_loaded", 1'b0, 1'b0);
      HREADYOUTM = 2'b11;
      #1;
      check_eq("hrdy_rdata", HRDATAS, 32'hBEEF_0002);
      step();

      // ---- saturation: 300 back-to-back unmapped NONSEQ ----
      drive_addr(1'b1, 29'h0002_0000, HTRANS_NONSEQ, 1'b0);
      for (int i = 0; i < 600; i++) step();
      drive_idle();
      step();
      step();
      step();
      check_eq("sat_cnt", {24'd0, err_count}, 32'd255);
      check_rsp("sat_idle", 1'b1, 1'b0);

      // ---- reset in the middle of ERR1 ----
      drive_addr(1'b1, 29'h0002_0000, HTRANS_NONSEQ, 1'b0);
      step();
      drive_idle();
      check_rsp("mid_err1", 1'b0, 1'b1);
      HRESETn = 1'b0;
      step();
      HRESETn = 1'b1;
      check_rsp("mid_rst", 1'b1, 1'b0);
      check_eq("mid_rst_cnt", {24'd0, err_count}, 32'd0);

`ifdef NANOSOC_EXP_TIMEOUT_EN
      // ---- hung target 0 ----
      begin
         int  waits;
         bit  done;
         waits = 0;
         done  = 1'b0;
         drive_addr(1'b1, 29'h0001_0000, HTRANS_NONSEQ, 1'b0);
         step();
         drive_idle();
         HREADYOUTM = 2'b10;
         #1;
         for (int c = 0; c < 40 && !done; c++) begin
            if (!HREADYOUTS && !HRESPS) begin
               waits++;
               step();
               #1;
            end else begin
               done = 1'b1;
            end
         end
         check_eq("to_waits", waits, 32'd16);
         check_rsp("to_err1", 1'b0, 1'b1);
         check_eq("to_fault", {30'd0, tgt_fault}, 32'h1);
         check_eq("to_cnt", {24'd0, err_count}, 32'd0);
         step();
         check_rsp("to_err2", 1'b1, 1'b1);
         step();
         HREADYOUTM = 2'b11;
         drive_addr(1'b1, 29'h0001_0000, HTRANS_NONSEQ, 1'b0);
         #1;
         check_eq("to_hselm", {30'd0, HSELM}, 32'h0);
         step();
         drive_idle();
         check_rsp("to_dec_err1", 1'b0, 1'b1);
         check_eq("to_dec_cnt", {24'd0, err_count}, 32'd1);
         step();
         check_rsp("to_dec_err2", 1'b1, 1'b1);
         step();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
